// File: rtl/frame_config_writer.sv
// Frame-interface configuration writer: assembles one NumRows-word frame per header
// and pulses a single FrameStrobe line. Optional parity check: FRAME_CONFIG_WRITER_PARITY_EN.
module frame_config_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 16,
    parameter int NumColumns      = 8
) (
    input  logic                                   UserCLK,
    input  logic                                   Reset,
    input  logic [31:0]                            WordIn,
    input  logic                                   WordValid,
    output logic                                   WordReady,
    output logic [FrameBitsPerRow*NumRows-1:0]     FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe,
    output logic                                   Busy,
    output logic                                   FrameError,
    output logic [15:0]                            FrameCount
);

    localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int StrobeW = MaxFramesPerCol * NumColumns;
    localparam int DataW   = FrameBitsPerRow * NumRows;

    localparam logic [RowW-1:0] LastRow  = RowW'(NumRows - 1);
    localparam logic [6:0]      ColLimit = 7'(NumColumns);
    localparam logic [7:0]      FrmLimit = 8'(MaxFramesPerCol);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHECK  = 2'd2,
        S_STROBE = 2'd3
    } state_t;

    function automatic logic parity32(input logic [31:0] word);
        return ^word;
    endfunction

    state_t               r_state;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_error;
    logic [15:0]          r_count;
    logic [DataW-1:0]     r_frame_data;
    logic [StrobeW-1:0]   r_strobe;
    logic [RowW-1:0]      r_row;
    logic [6:0]           r_col;
    logic [7:0]           r_frm;
    logic                 r_hdr_par;
    logic                 r_par_acc;

    logic                 w_xfer;
    logic                 w_reject;
    logic [15:0]          w_strobe_idx;
    logic                 w_unused_bits;

    assign w_xfer       = WordValid && r_ready;
    assign w_strobe_idx = (16'(r_col) * 16'(MaxFramesPerCol)) + 16'(r_frm);

    // Range check uses the full 7-bit column and 8-bit frame fields, never truncated.
`ifdef FRAME_CONFIG_WRITER_PARITY_EN
    assign w_reject      = (r_col >= ColLimit) || (r_frm >= FrmLimit) || (r_par_acc != r_hdr_par);
    assign w_unused_bits = ^WordIn[15:1];
`else
    assign w_reject      = (r_col >= ColLimit) || (r_frm >= FrmLimit);
    assign w_unused_bits = ^{WordIn[15:0], r_hdr_par, r_par_acc};
`endif

    // Frame sequencer: header capture, row loading, range/parity check and strobe.
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
            r_count      <= 16'd0;
            r_frame_data <= '0;
            r_strobe     <= '0;
            r_row        <= '0;
            r_col        <= 7'd0;
            r_frm        <= 8'd0;
            r_hdr_par    <= 1'b0;
            r_par_acc    <= 1'b0;
        end else begin
            r_strobe <= '0;
            r_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    // Words without bit31 set are dropped while hunting for a header.
                    if (w_xfer && WordIn[31]) begin
                        r_col     <= WordIn[30:24];
                        r_frm     <= WordIn[23:16];
                        r_hdr_par <= WordIn[0];
                        r_par_acc <= 1'b0;
                        r_row     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_frame_data[r_row*FrameBitsPerRow +: FrameBitsPerRow] <= WordIn;
                        r_par_acc <= r_par_acc ^ parity32(WordIn);
                        r_row     <= r_row + RowW'(1);
                        if (r_row == LastRow) begin
                            r_ready <= 1'b0;
                            r_state <= S_CHECK;
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_reject) begin
                        r_error <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_strobe <= StrobeW'(1) << w_strobe_idx;
                        r_count  <= r_count + 16'd1;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign WordReady   = r_ready;
    assign FrameData   = r_frame_data;
    assign FrameStrobe = r_strobe;
    assign Busy        = r_busy;
    assign FrameError  = r_error;
    assign FrameCount  = r_count;

endmodule

// File: doc/frame_config_writer.md
# frame_config_writer

Configuration-side driver for one fabric's frame interface. It accepts a 32-bit word stream over a valid/ready handshake and assembles one configuration frame per header. The frame consists of one data word per tile row. Once all rows are loaded, it pulses exactly one FrameStrobe line, selected by column and frame index. Its FrameStrobe and FrameData outputs feed the bottom of each fabric column. From there the strobes are buffered upward through every tile to the north terminal tiles.

## Interface
- MaxFramesPerCol, 20, frames per column; width of one column's strobe group
- FrameBitsPerRow, 32, bits per row per frame; must equal the input word width, 32
- NumRows, 16, tile rows; data words per frame
- NumColumns, 8, fabric columns
- UserCLK  input  1  single clock, rising edge
- Reset  input  1  synchronous, active-high
- WordIn  input  32  header or data word
- WordValid  input  1  WordIn valid
- WordReady  output  1  block can accept WordIn this cycle
- FrameData  output  FrameBitsPerRow*NumRows  row r occupies bits [32r+31:32r]
- FrameStrobe  output  MaxFramesPerCol*NumColumns  column c, frame f is bit c*MaxFramesPerCol+f
- Busy  output  1  high in LOAD and STROBE
- FrameError  output  1  one-cycle pulse when a frame is rejected
- FrameCount  output  16  count of strobed frames; wraps from 0xFFFF to 0

## Operation
- A transfer occurs on any UserCLK edge where WordValid and WordReady are both high.
- Header format:
  - bit31 is 1.
  - [30:24] is the column index.
  - [23:16] is the frame index.
  - [15:1] are reserved and ignored.
  - [0] is the parity bit; it is used only with the parity feature enabled.
- State machine, state IDLE:
  - WordReady is 1.
  - A transferred word with bit31 = 0 is discarded silently; this is sync hunting.
  - A transferred word with bit31 = 1 latches the column index, frame index and parity bit, clears the row counter, and moves to LOAD.
- State machine, state LOAD:
  - WordReady is 1.
  - Each transfer writes WordIn into row (row counter) of FrameData, then increments the row counter.
  - Data words are not inspected for bit31.
  - The transfer with row counter = NumRows-1 moves to CHECK.
- State machine, state CHECK:
  - WordReady is 0.
  - If column ≥ NumColumns, frame ≥ MaxFramesPerCol, or parity fails: pulse FrameError, leave FrameCount unchanged, and go to IDLE.
  - Otherwise go to STROBE.
- State machine, state STROBE:
  - WordReady is 0.
  - Exactly one FrameStrobe bit is 1 for this single cycle.
  - FrameCount increments.
  - Next state is IDLE.
- FrameData is registered. A row holds its value until overwritten by a later frame, so stale rows persist after an error.
- The row counter width is clog2(NumRows). The column and frame fields are compared at full 7 and 8 bits; they are never truncated before the range check.

## Timing
- Reset values:
  - state IDLE
  - WordReady 1 from the first cycle after Reset deasserts (0 while Reset is high)
  - FrameData all 0
  - FrameStrobe all 0
  - Busy 0
  - FrameError 0
  - FrameCount 0
- Last data word accepted at edge t:
  - CHECK occupies cycle t..t+1.
  - The FrameStrobe or FrameError pulse is high during cycle t+1..t+2.
  - WordReady returns to 1 at cycle t+2..t+3 after a strobe, or at t+1..t+2 after an error.
- Minimum frame period is NumRows+3 cycles.
- All outputs are registered; there are no combinational paths from input to output.
- When the strobe is high, FrameData already holds the complete frame and stays stable for that whole cycle.
- WordValid may drop mid-frame. LOAD waits indefinitely, and the row counter holds.
- Reset has priority over every state. Reset mid-LOAD:
  - The partial frame is abandoned.
  - No strobe is issued.
  - FrameData is cleared.
  - FrameCount is cleared.

## Configuration
- Macro: FRAME_CONFIG_WRITER_PARITY_EN.
- Defined:
  - The block computes even parity, the XOR of all NumRows×32 data bits, across the frame.
  - A mismatch against header bit 0 rejects the frame in CHECK.
- Undefined:
  - No parity logic is built.
  - Header bit 0 is ignored.
  - Parity never causes rejection.

## Test plan
- Header 0x8305_0000, then 16 data words 0x1000_0000+r with valid held high: FrameData row r equals 0x1000_0000+r. FrameStrobe bit 3*20+5 = 65 is high for exactly one cycle, 2 cycles after the last word. FrameCount = 1.
- Words 0x0000_1234 and 0x7FFF_FFFF in IDLE, then a valid frame: the first two words are dropped. FrameStrobe still fires once, at the bit selected by the valid frame's header.
- Header with column 8, or frame 20: all 16 data words are consumed. FrameError pulses once, with no FrameStrobe bit set and FrameCount unchanged.
- WordValid toggling 1/0 every cycle through LOAD: the strobe fires after the 16th accepted word, and row contents are correct.
- Reset asserted after the 7th data word: all outputs return to reset values the next cycle, and no strobe fires. A following full frame strobes normally.
- With FRAME_CONFIG_WRITER_PARITY_EN defined, data word 0x0000_0001 with rows 1..15 = 0:
  - Header bit 0 = 1 gives a strobe.
  - Header bit 0 = 0 gives FrameError and no strobe.
